// File: rtl/uart_tx_io.sv
// ---------------------------------------------------------------------------
// uart_tx_io
//   Memory-mapped UART transmitter on the 8-bit processor main bus.
//   The processor pushes bytes into a small transmit FIFO. A serial engine
//   sends them as 8N1 frames, or as 8E1 frames when UART_TX_PARITY_EN is
//   defined at compile time. An interrupt is raised when the transmitter
//   drains completely.
//
//   Register map (BASE_ADDR relative):
//     +0 DATA   (W)  push byte; dropped and OVF set when the FIFO is full
//     +1 STATUS (R)  {4'b0, OVF, BUSY, FULL, EMPTY}; any write clears OVF
//     +2 CTRL   (RW) bit0 TX_EN, bit1 IRQ_EN
//
//   Ports:
//     CLK                  system clock, rising edge
//     RESET                asynchronous active-low reset
//     BUS_DATA[7:0]        bidirectional bus data, driven for one cycle
//                          after a read address cycle, otherwise Z
//     BUS_ADDR[7:0]        bus address
//     BUS_WE               1 = write, 0 = read
//     BUS_INTERRUPT_RAISE  interrupt request, held until acknowledged
//     BUS_INTERRUPT_ACK    interrupt acknowledge
//     TX_OUT               serial line, idles high
//
//   Compile option: UART_TX_PARITY_EN adds an even-parity bit after DATA.
// ---------------------------------------------------------------------------
module uart_tx_io #(
    parameter logic [7:0] BASE_ADDR    = 8'hE0,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK,
    output logic       TX_OUT
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);

    localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1'b1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

    localparam logic [7:0] ADDR_DATA   = BASE_ADDR;
    localparam logic [7:0] ADDR_STATUS = BASE_ADDR + 8'd1;
    localparam logic [7:0] ADDR_CTRL   = BASE_ADDR + 8'd2;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Even parity over one data byte.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3
    } state_t;
`endif

    // Bus decode
    logic sel_data_s, sel_status_s, sel_ctrl_s, sel_any_s;
    logic push_req_s, push_s, pop_s, ovf_set_s, ovf_clr_s;
    logic empty_s, full_s, busy_s;
    logic [7:0] rd_mux_s, fifo_head_s;

    // Registers
    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          ovf_r, tx_en_r, irq_en_r;
    logic          rd_en_r;
    logic [7:0]    rd_data_r;
    logic          raise_r, tx_out_r;

    // Serial engine
    state_t        state_r, state_nx_s;
    logic [TW-1:0] timer_r;
    logic [2:0]    bit_cnt_r;
    logic [7:0]    shift_r;
    logic          timer_done_s, shift_s, stop_done_s, irq_evt_s, tx_bit_s;
`ifdef UART_TX_PARITY_EN
    logic          parity_r;
`endif

    assign sel_data_s   = (BUS_ADDR == ADDR_DATA);
    assign sel_status_s = (BUS_ADDR == ADDR_STATUS);
    assign sel_ctrl_s   = (BUS_ADDR == ADDR_CTRL);
    assign sel_any_s    = sel_data_s | sel_status_s | sel_ctrl_s;

    assign empty_s     = (count_r == {CW{1'b0}});
    assign full_s      = (count_r == CNT_FULL);
    assign busy_s      = (state_r != ST_IDLE);
    assign fifo_head_s = mem_r[rd_ptr_r];

    // A push into a full FIFO still lands when the engine pops in the same cycle.
    assign push_req_s = sel_data_s & BUS_WE;
    assign push_s     = push_req_s & (~full_s | pop_s);
    assign ovf_set_s  = push_req_s & full_s & ~pop_s;
    assign ovf_clr_s  = sel_status_s & BUS_WE;

    assign timer_done_s = (timer_r == TIMER_MAX);
    assign irq_evt_s    = stop_done_s & empty_s & irq_en_r;

    // Read-data multiplexer for the registered read path.
    always_comb begin
        rd_mux_s = 8'h00;
        if (sel_status_s) begin
            rd_mux_s = {4'b0000, ovf_r, busy_s, full_s, empty_s};
        end else if (sel_ctrl_s) begin
            rd_mux_s = {6'b000000, irq_en_r, tx_en_r};
        end else begin
            rd_mux_s = 8'h00;
        end
    end

    // Bus drive: the registered read strobe gives exactly one driven cycle.
    assign BUS_DATA = rd_en_r ? rd_data_r : 8'hZZ;

    // Registered read capture plus CTRL and OVF register updates.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_en_r   <= 1'b0;
            rd_data_r <= 8'h00;
            tx_en_r   <= 1'b0;
            irq_en_r  <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            rd_en_r   <= sel_any_s & ~BUS_WE;
            rd_data_r <= rd_mux_s;
            if (sel_ctrl_s && BUS_WE) begin
                tx_en_r  <= BUS_DATA[0];
                irq_en_r <= BUS_DATA[1];
            end
            // Set has priority over a simultaneous STATUS-write clear.
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr_s) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= BUS_DATA;
        end
    end

    // FIFO pointers and occupancy counter.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Serial FSM state register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Serial FSM next-state and control strobes.
    always_comb begin
        state_nx_s  = state_r;
        pop_s       = 1'b0;
        shift_s     = 1'b0;
        stop_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (tx_en_r && !empty_s) begin
                    pop_s      = 1'b1;
                    state_nx_s = ST_START;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (timer_done_s) begin
                    state_nx_s = ST_DATA;
                end else begin
                    state_nx_s = ST_START;
                end
            end
            ST_DATA: begin
                if (timer_done_s) begin
                    shift_s = 1'b1;
                    if (bit_cnt_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nx_s = ST_PARITY;
`else
                        state_nx_s = ST_STOP;
`endif
                    end else begin
                        state_nx_s = ST_DATA;
                    end
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (timer_done_s) begin
                    state_nx_s = ST_STOP;
                end else begin
                    state_nx_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (timer_done_s) begin
                    stop_done_s = 1'b1;
                    // Chain straight into the next frame when data is waiting.
                    if (tx_en_r && !empty_s) begin
                        pop_s      = 1'b1;
                        state_nx_s = ST_START;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else begin
                    state_nx_s = ST_STOP;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Line level selected by the current state.
    always_comb begin
        tx_bit_s = 1'b1;
        case (state_r)
            ST_START:  tx_bit_s = 1'b0;
            ST_DATA:   tx_bit_s = shift_r[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_bit_s = parity_r;
`endif
            default:   tx_bit_s = 1'b1;
        endcase
    end

    // Bit timer, shift register, bit counter and registered line output.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            timer_r   <= {TW{1'b0}};
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            tx_out_r  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            if ((state_r == ST_IDLE) || timer_done_s || (state_nx_s != state_r)) begin
                timer_r <= {TW{1'b0}};
            end else begin
                timer_r <= timer_r + TIMER_ONE;
            end
            if (pop_s) begin
                shift_r   <= fifo_head_s;
                bit_cnt_r <= 3'd0;
`ifdef UART_TX_PARITY_EN
                parity_r  <= even_parity(fifo_head_s);
`endif
            end else if (shift_s) begin
                shift_r   <= {1'b0, shift_r[7:1]};
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end
            tx_out_r <= tx_bit_s;
        end
    end

    // Interrupt request: a drain event wins over a same-cycle acknowledge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            raise_r <= 1'b0;
        end else if (irq_evt_s) begin
            raise_r <= 1'b1;
        end else if (BUS_INTERRUPT_ACK) begin
            raise_r <= 1'b0;
        end
    end

    assign BUS_INTERRUPT_RAISE = raise_r;
    assign TX_OUT              = tx_out_r;

endmodule

// File: tb/tb_uart_tx_io.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_io
//   Self-checking bench for uart_tx_io with CLKS_PER_BIT=4, FIFO_DEPTH=4.
//   Expected serial waveforms are built from byte lists as start/data/
//   (parity)/stop bit sequences. A pull-up makes an undriven bus read 8'hFF.
// ---------------------------------------------------------------------------
module tb_uart_tx_io;

    localparam int         CPB  = 4;
    localparam int         DEPTH = 4;
    localparam logic [7:0] BASE = 8'hE0;
    localparam logic [7:0] UNDRIVEN = 8'hFF;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] addr;
    logic       bus_we;
    logic       ack;
    logic [7:0] drv;
    logic       drv_en;
    wire  [7:0] bus_data;
    wire        raise;
    wire        tx;

    int checks = 0;
    int errors = 0;

    assign bus_data = drv_en ? drv : 8'hzz;

    for (genvar gi = 0; gi < 8; gi++) begin : g_pu
        pullup (bus_data[gi]);
    end

    always #5 clk = ~clk;

    uart_tx_io #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .CLK                (clk),
        .RESET              (rst_n),
        .BUS_DATA           (bus_data),
        .BUS_ADDR           (addr),
        .BUS_WE             (bus_we),
        .BUS_INTERRUPT_RAISE(raise),
        .BUS_INTERRUPT_ACK  (ack),
        .TX_OUT             (tx)
    );

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; bus_we = 1'b1; drv = d; drv_en = 1'b1;
        @(posedge clk);
        #1;
        addr = 8'h00; bus_we = 1'b0; drv_en = 1'b0;
    endtask

    // Returns the bus value in the cycle after the address cycle.
    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a; bus_we = 1'b0;
        @(posedge clk);
        #1;
        addr = 8'h00;
        @(negedge clk);
        d = bus_data;
    endtask

    // Called right after the edge that makes transmission possible:
    // the line stays high one more edge, then the start bit appears.
    task automatic expect_start(input string name);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL %s_early: tx=%b expected 1", name, tx);
        end
        @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL %s_start: tx=%b expected 0", name, tx);
        end
    endtask

    // Checks back-to-back frames cycle by cycle; the first start-bit cycle
    // is the current sample. Also reports RAISE on the last two samples.
    task automatic check_stream(input string name, input logic [7:0] bytes_q[$],
                                output logic raise_prev, output logic raise_last);
        logic bits_q[$];
        logic [7:0] b;
        bits_q = {};
        foreach (bytes_q[n]) begin
            b = bytes_q[n];
            bits_q.push_back(1'b0);
            for (int k = 0; k < 8; k++) bits_q.push_back(b[k]);
`ifdef UART_TX_PARITY_EN
            bits_q.push_back(^b);
`endif
            bits_q.push_back(1'b1);
        end
        raise_prev = 1'b0;
        raise_last = 1'b0;
        for (int i = 0; i < bits_q.size(); i++) begin
            for (int c = 0; c < CPB; c++) begin
                if (!(i == 0 && c == 0)) @(negedge clk);
                raise_prev = raise_last;
                raise_last = raise;
                checks++;
                if (tx !== bits_q[i]) begin
                    errors++;
                    $display("FAIL %s bit %0d cyc %0d: tx=%b expected %b", name, i, c, tx, bits_q[i]);
                end
            end
        end
    endtask

    task automatic check_reg(input string name, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        checks++;
        if (d !== exp) begin
            errors++;
            $display("FAIL %s: read %h expected %h", name, d, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; addr = 8'h00; bus_we = 1'b0; ack = 1'b0; drv = 8'h00; drv_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: tx=%b expected 1", tx); end
        checks++;
        if (raise !== 1'b0) begin errors++; $display("FAIL reset_raise: %b expected 0", raise); end
        checks++;
        if (bus_data !== UNDRIVEN) begin errors++; $display("FAIL reset_bus: %h expected %h", bus_data, UNDRIVEN); end
        @(negedge clk);
        rst_n = 1'b1;
        check_reg("reset_status", BASE + 8'd1, 8'h01);
        check_reg("reset_ctrl", BASE + 8'd2, 8'h00);
    endtask

    task automatic test_single_frame();
        logic [7:0] q[$];
        logic rp, rl;
        bus_write(BASE + 8'd2, 8'h01);
        bus_write(BASE, 8'hA5);
        expect_start("single");
        q = {8'hA5};
        check_stream("single", q, rp, rl);
        check_reg("single_status", BASE + 8'd1, 8'h01);
    endtask

    task automatic test_overflow_back_to_back();
        logic [7:0] q[$];
        logic [7:0] b;
        logic rp, rl;
        bus_write(BASE + 8'd2, 8'h00);
        q = {};
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            if (i < DEPTH) q.push_back(b);
            bus_write(BASE, b);
        end
        check_reg("ovf_status", BASE + 8'd1, 8'h0A);
        bus_write(BASE + 8'd1, 8'h00);
        check_reg("ovf_cleared", BASE + 8'd1, 8'h02);
        bus_write(BASE + 8'd2, 8'h01);
        expect_start("b2b");
        check_stream("b2b", q, rp, rl);
        check_reg("b2b_status", BASE + 8'd1, 8'h01);
    endtask

    task automatic test_irq();
        logic [7:0] q[$];
        logic rp, rl;
        bus_write(BASE + 8'd2, 8'h03);
        q = {8'($urandom)};
        bus_write(BASE, q[0]);
        expect_start("irq");
        check_stream("irq", q, rp, rl);
        checks++;
        if (rp !== 1'b0) begin errors++; $display("FAIL irq_early: raise=%b expected 0", rp); end
        checks++;
        if (rl !== 1'b1) begin errors++; $display("FAIL irq_rise: raise=%b expected 1", rl); end
        repeat (5) @(negedge clk);
        checks++;
        if (raise !== 1'b1) begin errors++; $display("FAIL irq_hold: raise=%b expected 1", raise); end
        ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
        @(negedge clk);
        checks++;
        if (raise !== 1'b0) begin errors++; $display("FAIL irq_ack: raise=%b expected 0", raise); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] q[$];
        logic rp, rl;
        q = {8'($urandom)};
        bus_write(BASE, q[0]);
        expect_start("pre_rst");
        check_stream("pre_rst", q, rp, rl);
        bus_write(BASE, 8'h00);
        expect_start("mid_rst");
        repeat (CPB + 2 * CPB) @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL mid_data: tx=%b expected 0", tx); end
        checks++;
        if (raise !== 1'b1) begin errors++; $display("FAIL mid_raise: raise=%b expected 1", raise); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx: tx=%b expected 1", tx); end
        checks++;
        if (raise !== 1'b0) begin errors++; $display("FAIL rst_raise: raise=%b expected 0", raise); end
        @(negedge clk);
        rst_n = 1'b1;
        check_reg("rst_status", BASE + 8'd1, 8'h01);
        check_reg("rst_ctrl", BASE + 8'd2, 8'h00);
    endtask

    task automatic test_bus_read();
        logic [7:0] d;
        bus_write(BASE + 8'd2, 8'h03);
        bus_read(BASE + 8'd3, d);
        checks++;
        if (d !== UNDRIVEN) begin errors++; $display("FAIL unmapped_read: %h expected %h", d, UNDRIVEN); end
        bus_read(BASE + 8'd2, d);
        checks++;
        if (d !== 8'h03) begin errors++; $display("FAIL ctrl_read: %h expected 03", d); end
        @(negedge clk);
        checks++;
        if (bus_data !== UNDRIVEN) begin errors++; $display("FAIL ctrl_release: %h expected %h", bus_data, UNDRIVEN); end
        bus_write(BASE + 8'd2, 8'h00);
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic rp, rl;
        int n;
        for (int r = 0; r < 6; r++) begin
            bus_write(BASE + 8'd2, 8'h00);
            n = $urandom_range(1, DEPTH);
            q = {};
            for (int i = 0; i < n; i++) begin
                q.push_back(8'($urandom));
                bus_write(BASE, q[i]);
            end
            bus_write(BASE + 8'd2, 8'h01);
            expect_start("rand");
            check_stream("rand", q, rp, rl);
            check_reg("rand_status", BASE + 8'd1, 8'h01);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] q[$];
        logic rp, rl;
        bus_write(BASE + 8'd2, 8'h01);
        bus_write(BASE, 8'h07);
        expect_start("parity");
        q = {8'h07};
        check_stream("parity", q, rp, rl);
        check_reg("parity_status", BASE + 8'd1, 8'h01);
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_overflow_back_to_back();
        test_irq();
        test_reset_mid_frame();
        test_bus_read();
        test_random();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
